cache_line_mem_unit: RTL

- Memory-side line engine, directly downstream of the cache datapath/control.
- Converts one 64-byte line operation into 16 single-word (4B) memory transactions:
  - refill: 16 reads;
  - writeback: 16 writes.
- Streams refill words back to the data array, one word per accepted response, with a word index.
- Tracks outstanding requests and reports line completion with a val/rdy response.

---
 rtl/cache_line_mem_unit.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cache_line_mem_unit.sv
// Memory-side line engine: turns one cache-line refill/writeback into per-word memory requests.
// Optional build macro CACHE_LINE_MEM_UNIT_CRITICAL_WORD_FIRST_EN starts issue at line_req_word.
module cache_line_mem_unit #(
  parameter int unsigned WORDS_PER_LINE  = 16,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           line_req_val,
  output logic                           line_req_rdy,
  input  logic                           line_req_wb,
  input  logic [ADDR_W-7:0]              line_req_addr,
  input  logic [$clog2(WORDS_PER_LINE)-1:0] line_req_word,
  input  logic [32*WORDS_PER_LINE-1:0]   line_req_wdata,
  output logic                           memreq_val,
  input  logic                           memreq_rdy,
  output logic [2:0]                     memreq_type,
  output logic [7:0]                     memreq_opaque,
  output logic [ADDR_W-1:0]              memreq_addr,
  output logic [1:0]                     memreq_len,
  output logic [31:0]                    memreq_data,
  input  logic                           memresp_val,
  output logic                           memresp_rdy,
  input  logic [7:0]                     memresp_opaque,
  input  logic [31:0]                    memresp_data,
  output logic                           fill_val,
  output logic [$clog2(WORDS_PER_LINE)-1:0] fill_idx,
  output logic [31:0]                    fill_data,
  output logic                           line_resp_val,
  input  logic                           line_resp_rdy
);

  localparam int unsigned IDX_W   = $clog2(WORDS_PER_LINE);
  localparam int unsigned CNT_W   = IDX_W + 1;
  localparam int unsigned LADDR_W = ADDR_W - 6;
  localparam int unsigned DATA_W  = 32 * WORDS_PER_LINE;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_wb;
  logic [LADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_issue_cnt;
  logic [CNT_W-1:0]    r_resp_cnt;
  logic [CNT_W-1:0]    r_outstanding;
  logic                r_fill_val;
  logic [IDX_W-1:0]    r_fill_idx;
  logic [31:0]         r_fill_data;
  logic [IDX_W-1:0]    w_start;
  logic [IDX_W-1:0]    w_idx;
  logic                w_accept;
  logic                w_req_fire;
  logic                w_resp_fire;
  logic                w_unused;

`ifdef CACHE_LINE_MEM_UNIT_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0]    r_start;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_start <= '0;
    else if (w_accept) r_start <= line_req_word;
  end

  assign w_start  = r_start;
  assign w_unused = ^memresp_opaque[7:IDX_W];
`else
  assign w_start  = '0;
  assign w_unused = ^{line_req_word, memresp_opaque[7:IDX_W]};
`endif

  // Issue index wraps naturally in IDX_W bits.
  assign w_idx       = w_start + r_issue_cnt[IDX_W-1:0];
  assign w_accept    = line_req_val & line_req_rdy;
  assign w_req_fire  = memreq_val & memreq_rdy;
  assign w_resp_fire = memresp_val & memresp_rdy;

  assign memreq_type   = r_wb ? 3'd1 : 3'd0;
  assign memreq_opaque = 8'(w_idx);
  assign memreq_addr   = ADDR_W'({r_addr, w_idx, 2'b00});
  assign memreq_len    = 2'd0;
  assign memreq_data   = r_wb ? r_wdata[{w_idx, 5'd0} +: 32] : 32'd0;
  assign fill_val      = r_fill_val;
  assign fill_idx      = r_fill_idx;
  assign fill_data     = r_fill_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    line_req_rdy  = 1'b0;
    memreq_val    = 1'b0;
    memresp_rdy   = 1'b0;
    line_resp_val = 1'b0;
    case (r_state)
      S_IDLE: begin
        line_req_rdy = 1'b1;
        if (line_req_val) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        memreq_val  = (r_outstanding < CNT_W'(MAX_OUTSTANDING));
        memresp_rdy = (r_outstanding != '0);
        if (memreq_val && memreq_rdy && (r_issue_cnt == CNT_W'(WORDS_PER_LINE - 1)))
          w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        memresp_rdy = (r_outstanding != '0);
        // Last fill strobe is already out when resp_cnt is seen full.
        if (r_resp_cnt == CNT_W'(WORDS_PER_LINE)) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        line_resp_val = 1'b1;
        if (line_resp_rdy) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wb          <= 1'b0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_issue_cnt   <= '0;
      r_resp_cnt    <= '0;
      r_outstanding <= '0;
      r_fill_val    <= 1'b0;
      r_fill_idx    <= '0;
      r_fill_data   <= '0;
    end else begin
      r_fill_val <= w_resp_fire & ~r_wb;
      if (w_resp_fire) begin
        r_fill_idx  <= memresp_opaque[IDX_W-1:0];
        r_fill_data <= memresp_data;
      end
      if (w_accept) begin
        r_wb          <= line_req_wb;
        r_addr        <= line_req_addr;
        r_wdata       <= line_req_wdata;
        r_issue_cnt   <= '0;
        r_resp_cnt    <= '0;
        r_outstanding <= '0;
      end else begin
        if (w_req_fire)  r_issue_cnt <= r_issue_cnt + CNT_W'(1);
        if (w_resp_fire) r_resp_cnt  <= r_resp_cnt + CNT_W'(1);
        case ({w_req_fire, w_resp_fire})
          2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
          2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
          default: r_outstanding <= r_outstanding;
        endcase
      end
    end
  end

endmodule
